// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: round-robin shared AND/OR/XOR/ADD datapath for two valid/ready requesters
// with a single-entry tagged response register.
module alu_rr_scheduler #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_carry
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t state, state_next;
    logic last_grant, slot_free, grant, xfer, carry;
    logic [1:0] sel_op;
    logic [WIDTH-1:0] sel_a, sel_b, result;
    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else state <= state_next;
    end
    always_comb begin
        state_next = state;
        if (xfer) state_next = FULL;
        else if (state == FULL && rsp_ready) state_next = EMPTY;
    end
    always_comb begin
        rsp_valid = (state == FULL);
    end
    // A draining slot can accept a new op in the same cycle.
    always_comb begin
        slot_free  = (state == EMPTY) | rsp_ready;
        xfer       = !rst & slot_free & (req0_valid | req1_valid);
        grant      = (req0_valid & req1_valid) ? !last_grant : (req1_valid & !req0_valid);
        req0_ready = xfer & !grant;
        req1_ready = xfer & grant;
    end
    always_comb begin
        sel_op = grant ? req1_op : req0_op;
        sel_a  = grant ? req1_a : req0_a;
        sel_b  = grant ? req1_b : req0_b;
        {carry, result} = (sel_op == 2'b00) ? {1'b0, sel_a & sel_b} :
                          (sel_op == 2'b01) ? {1'b0, sel_a | sel_b} :
                          (sel_op == 2'b10) ? {1'b0, sel_a ^ sel_b} :
                                              {1'b0, sel_a} + {1'b0, sel_b};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            rsp_carry  <= 1'b0;
            last_grant <= 1'b1;
        end else if (xfer) begin
            rsp_id     <= grant;
            rsp_data   <= result;
            rsp_carry  <= carry;
            last_grant <= grant;
        end
    end
endmodule
